// File: rtl/brisc_pkg.sv
// Shared memory-interface types for the cache/memory subsystem.
package brisc_pkg;

   localparam int ADDRESS_WIDTH = 32;
   localparam int LINE_WIDTH    = 128;

   typedef struct packed {
      logic                     valid;
      logic                     rw;      // 1 = write-back, 0 = refill read
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [LINE_WIDTH-1:0]    data;
   } mem_req_t;

   typedef struct packed {
      logic                     ready;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [LINE_WIDTH-1:0]    data;
   } mem_resp_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } arb_owner_t;

   function automatic arb_owner_t other_owner(input arb_owner_t owner);
      return (owner == OWNER_I) ? OWNER_D : OWNER_I;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin pick between the I-cache and D-cache requests.
module mem_arbiter_rr
   import brisc_pkg::*;
(
   input  logic       ic_valid,
   input  logic       dc_valid,
   input  arb_owner_t rr_last,
   output logic       pick_valid,
   output arb_owner_t pick
);

   // On a tie the requester that did not own the port last time wins.
   always_comb begin
      pick_valid = ic_valid | dc_valid;
      pick       = OWNER_I;
      if (ic_valid && dc_valid) begin
         pick = other_owner(rr_last);
      end else if (dc_valid) begin
         pick = OWNER_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single line-wide memory port between the I-cache and D-cache.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; pick the next owner from pending requests
//   OWN_I | I-cache owns the port (write-back and refill)
//   OWN_D | D-cache owns the port (write-back and refill)
//   DRAIN | owner released with a read outstanding; swallow its response
module mem_arbiter
   import brisc_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = 255,
   parameter int CNT_WIDTH     = 8
) (
   input  logic      clk,
   input  logic      reset,
   input  mem_req_t  ic_mem_req,
   input  mem_req_t  dc_mem_req,
   input  mem_resp_t mem_resp,
   output mem_req_t  mem_req,
   output mem_resp_t ic_mem_resp,
   output mem_resp_t dc_mem_resp,
   output logic      ic_grant,
   output logic      dc_grant,
   output logic      drain_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_I = 2'd1,
      OWN_D = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Counter value seen during the last DRAIN cycle before giving up.
   localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DRAIN_TIMEOUT - 1);

   state_t               state;
   logic                 pending;
   arb_owner_t           rr_last;
   logic [CNT_WIDTH-1:0] drain_cnt;
   logic                 pick_valid;
   arb_owner_t           pick;
   logic                 owned;
   logic                 drain_expire;

   mem_arbiter_rr u_rr (
      .ic_valid   (ic_mem_req.valid),
      .dc_valid   (dc_mem_req.valid),
      .rr_last    (rr_last),
      .pick_valid (pick_valid),
      .pick       (pick)
   );

   assign owned        = (state == OWN_I) || (state == OWN_D);
   assign drain_expire = (state == DRAIN) && !mem_resp.ready && (drain_cnt == DRAIN_LAST);

   // Forward the owner's request and return the response to the owner only.
   always_comb begin
      mem_req           = '0;
      ic_mem_resp       = mem_resp;
      dc_mem_resp       = mem_resp;
      ic_mem_resp.ready = 1'b0;
      dc_mem_resp.ready = 1'b0;
      case (state)
         OWN_I: begin
            mem_req           = ic_mem_req;
            ic_mem_resp.ready = mem_resp.ready;
         end
         OWN_D: begin
            mem_req           = dc_mem_req;
            dc_mem_resp.ready = mem_resp.ready;
         end
         default: ;
      endcase
   end

   // Ownership FSM with registered grants, outstanding-read tracking and drain timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ic_grant  <= 1'b0;
         dc_grant  <= 1'b0;
         pending   <= 1'b0;
         rr_last   <= OWNER_I;
         drain_cnt <= '0;
         drain_err <= 1'b0;
      end else begin
         drain_err <= 1'b0;

         // A response always retires the outstanding read, even if a new
         // read is on the bus; the held request re-arms it next cycle.
         if (mem_resp.ready || drain_expire) begin
            pending <= 1'b0;
         end else if (owned && mem_req.valid && !mem_req.rw) begin
            pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (pick_valid) begin
                  if (pick == OWNER_I) begin
                     state    <= OWN_I;
                     ic_grant <= 1'b1;
                  end else begin
                     state    <= OWN_D;
                     dc_grant <= 1'b1;
                  end
               end
            end
            OWN_I: begin
               if (!ic_mem_req.valid) begin
                  ic_grant <= 1'b0;
                  rr_last  <= OWNER_I;
                  state    <= (!pending || mem_resp.ready) ? IDLE : DRAIN;
               end
            end
            OWN_D: begin
               if (!dc_mem_req.valid) begin
                  dc_grant <= 1'b0;
                  rr_last  <= OWNER_D;
                  state    <= (!pending || mem_resp.ready) ? IDLE : DRAIN;
               end
            end
            DRAIN: begin
               if (mem_resp.ready) begin
                  state     <= IDLE;
                  drain_cnt <= '0;
               end else if (drain_expire) begin
                  state     <= IDLE;
                  drain_cnt <= '0;
                  drain_err <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (DRAIN_TIMEOUT = 8).
module tb_mem_arbiter;
   import brisc_pkg::*;

   logic      clk;
   logic      reset;
   mem_req_t  ic_req;
   mem_req_t  dc_req;
   mem_resp_t resp;
   mem_req_t  mreq;
   mem_resp_t ic_resp;
   mem_resp_t dc_resp;
   logic      ic_grant;
   logic      dc_grant;
   logic      drain_err;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [LINE_WIDTH-1:0] DB = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
   localparam logic [LINE_WIDTH-1:0] WB = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

   mem_arbiter #(.DRAIN_TIMEOUT(8), .CNT_WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .ic_mem_req  (ic_req),
      .dc_mem_req  (dc_req),
      .mem_resp    (resp),
      .mem_req     (mreq),
      .ic_mem_resp (ic_resp),
      .dc_mem_resp (dc_resp),
      .ic_grant    (ic_grant),
      .dc_grant    (dc_grant),
      .drain_err   (drain_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic mem_req_t rq(input logic v, input logic rw,
                                   input logic [ADDRESS_WIDTH-1:0] a,
                                   input logic [LINE_WIDTH-1:0] d);
      mem_req_t r;
      r.valid = v;
      r.rw    = rw;
      r.addr  = a;
      r.data  = d;
      return r;
   endfunction

   function automatic mem_resp_t rs(input logic rdy,
                                    input logic [ADDRESS_WIDTH-1:0] a,
                                    input logic [LINE_WIDTH-1:0] d);
      mem_resp_t r;
      r.ready = rdy;
      r.addr  = a;
      r.data  = d;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge, where inputs are driven.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic grants(input string tag, input logic exp_i, input logic exp_d);
      chk({tag, "_ic_grant"}, 256'(ic_grant), 256'(exp_i));
      chk({tag, "_dc_grant"}, 256'(dc_grant), 256'(exp_d));
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      ic_req = '0;
      dc_req = '0;
      resp   = '0;
      next();
      next();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset, then D-cache read miss ----
      do_reset();
      #1;
      grants("rst", 1'b0, 1'b0);
      chk("rst_mem_req", 256'(mreq), 256'(0));
      chk("rst_drain_err", 256'(drain_err), 256'(0));
      reset  = 1'b0;
      dc_req = rq(1'b1, 1'b0, 32'h0000_1040, '0);
      #1;
      chk("t1_latency_dc_grant", 256'(dc_grant), 256'(0));
      chk("t1_latency_mem_req", 256'(mreq), 256'(0));
      next(); #1;
      grants("t1_grant", 1'b0, 1'b1);
      chk("t1_mem_req", 256'(mreq), 256'(rq(1'b1, 1'b0, 32'h0000_1040, '0)));
      next();
      resp = rs(1'b1, 32'h0000_1040, DB);
      #1;
      chk("t1_dc_resp", 256'(dc_resp), 256'(rs(1'b1, 32'h0000_1040, DB)));
      chk("t1_ic_resp_ready", 256'(ic_resp.ready), 256'(0));
      chk("t1_ic_resp_data", 256'(ic_resp.data), 256'(DB));
      next();
      resp   = '0;
      dc_req = '0;
      #1;
      chk("t1_hold_to_drop", 256'(dc_grant), 256'(1));
      next(); #1;
      grants("t1_release", 1'b0, 1'b0);

      // ---- simultaneous requests from reset: D first, then I, then D ----
      do_reset();
      reset  = 1'b0;
      ic_req = rq(1'b1, 1'b0, 32'h0000_0100, '0);
      dc_req = rq(1'b1, 1'b0, 32'h0000_0200, '0);
      next(); #1;
      grants("t2_first_tie", 1'b0, 1'b1);
      chk("t2_mem_req_addr", 256'(mreq.addr), 256'(32'h0000_0200));
      next();
      resp = rs(1'b1, 32'h0000_0200, DB);
      #1;
      chk("t2_ic_resp_gated", 256'(ic_resp.ready), 256'(0));
      chk("t2_dc_resp_ready", 256'(dc_resp.ready), 256'(1));
      next();
      resp   = '0;
      dc_req = '0;
      next(); #1;
      grants("t2_idle_gap", 1'b0, 1'b0);
      next(); #1;
      grants("t2_i_turn", 1'b1, 1'b0);
      chk("t2_mem_req_i", 256'(mreq), 256'(rq(1'b1, 1'b0, 32'h0000_0100, '0)));
      resp = rs(1'b1, 32'h0000_0100, DB);
      #1;
      chk("t2_ic_resp_ready", 256'(ic_resp.ready), 256'(1));
      chk("t2_dc_resp_gated", 256'(dc_resp.ready), 256'(0));
      next();
      resp   = '0;
      ic_req = '0;
      dc_req = rq(1'b1, 1'b0, 32'h0000_0210, '0);
      next();
      ic_req = rq(1'b1, 1'b0, 32'h0000_0110, '0);
      #1;
      grants("t2_idle_gap2", 1'b0, 1'b0);
      next(); #1;
      grants("t2_second_tie", 1'b0, 1'b1);
      ic_req = '0;
      dc_req = '0;
      next(); #1;
      grants("t2_release", 1'b0, 1'b0);

      // ---- D dirty miss: write-back then refill under one grant ----
      dc_req = rq(1'b1, 1'b1, 32'h0000_2000, WB);
      next(); #1;
      grants("t3_wb_grant", 1'b0, 1'b1);
      chk("t3_wb_mem_req", 256'(mreq), 256'(rq(1'b1, 1'b1, 32'h0000_2000, WB)));
      resp = rs(1'b1, 32'h0000_2000, '0);
      next();
      resp   = '0;
      dc_req = rq(1'b1, 1'b0, 32'h0000_3000, '0);
      #1;
      chk("t3_hold_grant", 256'(dc_grant), 256'(1));
      chk("t3_refill_mem_req", 256'(mreq), 256'(rq(1'b1, 1'b0, 32'h0000_3000, '0)));
      next();
      resp = rs(1'b1, 32'h0000_3000, DB);
      #1;
      chk("t3_refill_grant", 256'(dc_grant), 256'(1));
      chk("t3_refill_resp", 256'(dc_resp), 256'(rs(1'b1, 32'h0000_3000, DB)));
      next();
      resp   = '0;
      dc_req = '0;
      next(); #1;
      grants("t3_release", 1'b0, 1'b0);

      // ---- I-cache drops with read pending: DRAIN swallows late response ----
      ic_req = rq(1'b1, 1'b0, 32'h0000_0400, '0);
      next(); #1;
      grants("t4_grant_i", 1'b1, 1'b0);
      dc_req = rq(1'b1, 1'b0, 32'h0000_4400, '0);
      #1;
      chk("t4_nonowner_grant", 256'(dc_grant), 256'(0));
      chk("t4_mem_req_owner", 256'(mreq), 256'(rq(1'b1, 1'b0, 32'h0000_0400, '0)));
      next();
      ic_req = '0;
      next(); #1;
      grants("t4_drain", 1'b0, 1'b0);
      chk("t4_drain_mem_req", 256'(mreq), 256'(0));
      next();
      next();
      next();
      next();
      resp = rs(1'b1, 32'h0000_0400, DB);
      #1;
      chk("t4_drain_ic_resp", 256'(ic_resp.ready), 256'(0));
      chk("t4_drain_dc_resp", 256'(dc_resp.ready), 256'(0));
      chk("t4_drain_dc_grant", 256'(dc_grant), 256'(0));
      next();
      resp = '0;
      #1;
      chk("t4_idle_dc_grant", 256'(dc_grant), 256'(0));
      next(); #1;
      chk("t4_dc_grant_rise", 256'(dc_grant), 256'(1));
      chk("t4_no_drain_err", 256'(drain_err), 256'(0));
      dc_req = '0;
      next();

      // ---- DRAIN timeout with no response ----
      ic_req = rq(1'b1, 1'b0, 32'h0000_0500, '0);
      next(); #1;
      grants("t5_grant_i", 1'b1, 1'b0);
      next();
      ic_req = '0;
      for (int i = 0; i < 8; i++) begin
         next(); #1;
         chk("t5_drain_err_early", 256'(drain_err), 256'(0));
      end
      grants("t5_last_drain", 1'b0, 1'b0);
      next(); #1;
      chk("t5_drain_err_pulse", 256'(drain_err), 256'(1));
      grants("t5_idle", 1'b0, 1'b0);
      next(); #1;
      chk("t5_drain_err_once", 256'(drain_err), 256'(0));
      dc_req = rq(1'b1, 1'b1, 32'h0000_5000, WB);
      next(); #1;
      chk("t5_dc_after_timeout", 256'(dc_grant), 256'(1));
      dc_req = '0;
      next(); #1;
      grants("t5_dc_release", 1'b0, 1'b0);
      ic_req = rq(1'b1, 1'b1, 32'h0000_5100, WB);
      next(); #1;
      chk("t5_pending_cleared", 256'(ic_grant), 256'(1));
      ic_req = '0;
      next();

      // ---- reset while D owns the port with a read pending ----
      dc_req = rq(1'b1, 1'b0, 32'h0000_0600, '0);
      next(); #1;
      chk("t6_grant_d", 256'(dc_grant), 256'(1));
      next();
      reset = 1'b1;
      next(); #1;
      grants("t6_after_reset", 1'b0, 1'b0);
      chk("t6_mem_req_zero", 256'(mreq), 256'(0));
      reset  = 1'b0;
      dc_req = '0;
      resp   = rs(1'b1, 32'h0000_0600, DB);
      #1;
      chk("t6_ic_resp_gated", 256'(ic_resp.ready), 256'(0));
      chk("t6_dc_resp_gated", 256'(dc_resp.ready), 256'(0));
      next();
      resp = '0;
      #1;
      grants("t6_idle", 1'b0, 1'b0);
      chk("t6_drain_err", 256'(drain_err), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
